// File: rtl/rob_pkg.sv
// ============================================================================
// Module   : rob_pkg
// Brief    : Shared widths, kind codes and helpers for the reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef ROB_SIZE
`define ROB_SIZE (1 << `ROB_WIDTH)
`endif
`ifndef ROB_KIND_REG
`define ROB_KIND_REG 2'd0
`endif
`ifndef ROB_KIND_BR
`define ROB_KIND_BR 2'd1
`endif
`ifndef ROB_KIND_ST
`define ROB_KIND_ST 2'd2
`endif

package rob_pkg;

   localparam int ROB_WIDTH_DEF = `ROB_WIDTH;
   localparam int ROB_SIZE_DEF  = `ROB_SIZE;
   localparam int XLEN          = 32;
   localparam int REG_W         = 5;

   typedef enum logic [1:0] {
      KIND_REG = `ROB_KIND_REG,
      KIND_BR  = `ROB_KIND_BR,
      KIND_ST  = `ROB_KIND_ST
   } rob_kind_e;

   // A branch entry's value is its resolved next PC.
   function automatic logic is_mispredict(input logic [1:0] kind,
                                          input logic [XLEN-1:0] value,
                                          input logic [XLEN-1:0] pred);
      return (kind == KIND_BR) && (value != pred);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rob_if.sv
// ============================================================================
// Module   : rob_if
// Brief    : Decoder / result-bus / commit signals of the reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rob_if import rob_pkg::*; #(
   parameter int ROB_WIDTH = ROB_WIDTH_DEF
) ();

   logic                 rob_full;
   logic [ROB_WIDTH-1:0] rob_free_id;

   logic                 dec_ready;
   logic [1:0]           dec_kind;
   logic [REG_W-1:0]     dec_rd;
   logic [XLEN-1:0]      dec_pred;
   logic                 dec_val_ready;
   logic [XLEN-1:0]      dec_value;

   logic                 rs_ready;
   logic [ROB_WIDTH-1:0] rs_rob_id;
   logic [XLEN-1:0]      rs_value;

   logic                 lsb_ready;
   logic [ROB_WIDTH-1:0] lsb_rob_id;
   logic [XLEN-1:0]      lsb_value;

   logic [ROB_WIDTH-1:0] qj_id;
   logic [ROB_WIDTH-1:0] qk_id;
   logic                 qj_ready;
   logic                 qk_ready;
   logic [XLEN-1:0]      qj_value;
   logic [XLEN-1:0]      qk_value;

   logic                 cmt_valid;
   logic [1:0]           cmt_kind;
   logic [REG_W-1:0]     cmt_rd;
   logic [XLEN-1:0]      cmt_value;
   logic [ROB_WIDTH-1:0] cmt_rob_id;
   logic                 clear;
   logic [XLEN-1:0]      redirect_pc;

   modport master (
      output dec_ready, dec_kind, dec_rd, dec_pred, dec_val_ready, dec_value,
      output rs_ready, rs_rob_id, rs_value,
      output lsb_ready, lsb_rob_id, lsb_value,
      output qj_id, qk_id,
      input  rob_full, rob_free_id,
      input  qj_ready, qk_ready, qj_value, qk_value,
      input  cmt_valid, cmt_kind, cmt_rd, cmt_value, cmt_rob_id,
      input  clear, redirect_pc
   );

   modport slave (
      input  dec_ready, dec_kind, dec_rd, dec_pred, dec_val_ready, dec_value,
      input  rs_ready, rs_rob_id, rs_value,
      input  lsb_ready, lsb_rob_id, lsb_value,
      input  qj_id, qk_id,
      output rob_full, rob_free_id,
      output qj_ready, qk_ready, qj_value, qk_value,
      output cmt_valid, cmt_kind, cmt_rd, cmt_value, cmt_rob_id,
      output clear, redirect_pc
   );

endinterface

`default_nettype wire

// File: rtl/rob.sv
// ============================================================================
// Module   : rob
// Brief    : Circular reorder buffer with in-order commit, mispredict flush
//            and same-cycle operand bypass from the RS and LSB result buses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob import rob_pkg::*; #(
   parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
   input  wire logic clk_in,
   input  wire logic rst_in,
   input  wire logic rdy_in,
   rob_if.slave      bus
);

   localparam int                 ROB_SIZE     = 1 << ROB_WIDTH;
   localparam logic [ROB_WIDTH:0] C_FULL_COUNT = (ROB_WIDTH + 1)'(ROB_SIZE);

   // Entry state
   logic [ROB_SIZE-1:0]  r_busy;
   logic [ROB_SIZE-1:0]  r_val_ready;
   logic [1:0]           r_kind  [ROB_SIZE];
   logic [REG_W-1:0]     r_rd    [ROB_SIZE];
   logic [XLEN-1:0]      r_pred  [ROB_SIZE];
   logic [XLEN-1:0]      r_value [ROB_SIZE];

   logic [ROB_WIDTH-1:0] r_head;
   logic [ROB_WIDTH-1:0] r_tail;
   logic [ROB_WIDTH:0]   r_count;

   // Registered commit / flush outputs
   logic                 r_cmt_valid;
   logic [1:0]           r_cmt_kind;
   logic [REG_W-1:0]     r_cmt_rd;
   logic [XLEN-1:0]      r_cmt_value;
   logic [ROB_WIDTH-1:0] r_cmt_rob_id;
   logic                 r_clear;
   logic [XLEN-1:0]      r_redirect_pc;

   logic                 w_full;
   logic                 w_commit;
   logic                 w_mispredict;
   logic                 w_alloc;
   logic [ROB_SIZE-1:0]  w_wb_hit;
   logic [XLEN-1:0]      w_wb_value [ROB_SIZE];

   assign w_full       = (r_count == C_FULL_COUNT);
   assign w_commit     = r_busy[r_head] & r_val_ready[r_head] & ~r_clear;
   assign w_mispredict = w_commit & is_mispredict(r_kind[r_head], r_value[r_head], r_pred[r_head]);
   // Fullness is judged before this cycle's commit, so a retiring head frees its slot.
   assign w_alloc      = bus.dec_ready & ~r_clear & (~w_full | w_commit);

   for (genvar i = 0; i < ROB_SIZE; i++) begin : g_entry
      logic w_rs_hit;
      logic w_lsb_hit;
      assign w_rs_hit      = bus.rs_ready  && (bus.rs_rob_id  == ROB_WIDTH'(i));
      assign w_lsb_hit     = bus.lsb_ready && (bus.lsb_rob_id == ROB_WIDTH'(i));
      assign w_wb_hit[i]   = ~r_clear & r_busy[i] & (w_rs_hit | w_lsb_hit);
      assign w_wb_value[i] = w_rs_hit ? bus.rs_value : bus.lsb_value;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_busy        <= '0;
         r_val_ready   <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_cmt_valid   <= 1'b0;
         r_cmt_kind    <= '0;
         r_cmt_rd      <= '0;
         r_cmt_value   <= '0;
         r_cmt_rob_id  <= '0;
         r_clear       <= 1'b0;
         r_redirect_pc <= '0;
      end else if (rdy_in) begin
         r_cmt_valid <= w_commit;
         r_clear     <= w_mispredict;
         if (w_commit) begin
            r_cmt_kind   <= r_kind[r_head];
            r_cmt_rd     <= r_rd[r_head];
            r_cmt_value  <= r_value[r_head];
            r_cmt_rob_id <= r_head;
         end
         if (w_mispredict) begin
            r_redirect_pc <= r_value[r_head];
            r_busy        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
         end else begin
            if (w_commit) begin
               r_head <= r_head + 1'b1;
            end
            if (w_alloc) begin
               r_tail <= r_tail + 1'b1;
            end
            r_count <= r_count + {{ROB_WIDTH{1'b0}}, w_alloc} - {{ROB_WIDTH{1'b0}}, w_commit};
            // A new allocation overrides a same-cycle retire or writeback of that slot.
            for (int i = 0; i < ROB_SIZE; i++) begin
               if (w_alloc && (r_tail == ROB_WIDTH'(i))) begin
                  r_busy[i]      <= 1'b1;
                  r_val_ready[i] <= bus.dec_val_ready;
               end else begin
                  if (w_commit && (r_head == ROB_WIDTH'(i))) begin
                     r_busy[i] <= 1'b0;
                  end
                  if (w_wb_hit[i]) begin
                     r_val_ready[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   // Payload fields are only meaningful while busy, so they carry no reset.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            if (w_alloc && (r_tail == ROB_WIDTH'(i))) begin
               r_kind[i]  <= bus.dec_kind;
               r_rd[i]    <= bus.dec_rd;
               r_pred[i]  <= bus.dec_pred;
               r_value[i] <= bus.dec_value;
            end else if (w_wb_hit[i]) begin
               r_value[i] <= w_wb_value[i];
            end
         end
      end
   end

   logic [ROB_WIDTH-1:0] w_q_id [2];
   assign w_q_id[0] = bus.qj_id;
   assign w_q_id[1] = bus.qk_id;

   for (genvar g = 0; g < 2; g++) begin : g_query
      logic            w_ready;
      logic [XLEN-1:0] w_value;
      always_comb begin
         w_ready = r_val_ready[w_q_id[g]];
         w_value = r_value[w_q_id[g]];
         if (bus.rs_ready && (bus.rs_rob_id == w_q_id[g])) begin
            w_ready = 1'b1;
            w_value = bus.rs_value;
         end else if (bus.lsb_ready && (bus.lsb_rob_id == w_q_id[g])) begin
            w_ready = 1'b1;
            w_value = bus.lsb_value;
         end
      end
   end

   assign bus.qj_ready    = g_query[0].w_ready;
   assign bus.qj_value    = g_query[0].w_value;
   assign bus.qk_ready    = g_query[1].w_ready;
   assign bus.qk_value    = g_query[1].w_value;

   assign bus.rob_full    = w_full;
   assign bus.rob_free_id = r_tail;
   assign bus.cmt_valid   = r_cmt_valid;
   assign bus.cmt_kind    = r_cmt_kind;
   assign bus.cmt_rd      = r_cmt_rd;
   assign bus.cmt_value   = r_cmt_value;
   assign bus.cmt_rob_id  = r_cmt_rob_id;
   assign bus.clear       = r_clear;
   assign bus.redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire
